// File: rtl/vm_match_engine_pkg.sv
// Shared definitions for the VM match engine: VM word layout, FSM states
// and the fine-phi distance helper.
package vm_match_engine_pkg;

    // VM projection / stub word: {index[12:6], zbin[5:3], phi_fine[2:0]}
    localparam int unsigned WORD_W   = 13;
    localparam int unsigned INDEX_HI = 12;
    localparam int unsigned INDEX_LO = 6;
    localparam int unsigned ZBIN_HI  = 5;
    localparam int unsigned ZBIN_LO  = 3;
    localparam int unsigned PHI_HI   = 2;
    localparam int unsigned PHI_LO   = 0;
    localparam int unsigned PHI_W    = PHI_HI - PHI_LO + 1;
    localparam int unsigned DIST_W   = PHI_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SCAN = 3'd2,
        ST_NEXT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Unsigned |a - b| of two fine-phi fields, one bit wider than the fields
    function automatic logic [DIST_W-1:0] phi_dist(input logic [PHI_W-1:0] a,
                                                   input logic [PHI_W-1:0] b);
        return (a >= b) ? DIST_W'(a - b) : DIST_W'(b - a);
    endfunction

endpackage

// File: rtl/vm_match_compare.sv
// Compatibility test of one (projection, stub) pair plus its output register.
// hit_c is the raw combinational verdict; hit/pair are the registered result,
// only updated when the caller enables the write.
module vm_match_compare
    import vm_match_engine_pkg::*;
#(
    parameter int unsigned IDX_W   = 7,
    parameter int unsigned PHI_TOL = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [WORD_W-1:0]    proj_word,
    input  logic [WORD_W-1:0]    stub_word,
    output logic                 hit_c,
    output logic                 hit,
    output logic [2*IDX_W-1:0]   pair
);

    logic              zbin_eq_c;
    logic [DIST_W-1:0] phi_d_c;

    assign zbin_eq_c = (proj_word[ZBIN_HI:ZBIN_LO] == stub_word[ZBIN_HI:ZBIN_LO]);
    assign phi_d_c   = phi_dist(proj_word[PHI_HI:PHI_LO], stub_word[PHI_HI:PHI_LO]);
    assign hit_c     = zbin_eq_c && (phi_d_c <= DIST_W'(PHI_TOL));

    // Register the verdict and the index pair of an accepted match
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit  <= 1'b0;
            pair <= '0;
        end else begin
            hit <= en && hit_c;
            if (en && hit_c) begin
                pair <= {IDX_W'(proj_word[INDEX_HI:INDEX_LO]),
                         IDX_W'(stub_word[INDEX_HI:INDEX_LO])};
            end
        end
    end

endmodule

// File: rtl/vm_match_engine.sv
// VM match engine: for each stored VM projection, scans all VM stubs and
// writes every z-bin / fine-phi compatible pair into the candidate memory.
module vm_match_engine
    import vm_match_engine_pkg::*;
#(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned IDX_W   = 7,
    parameter int unsigned PHI_TOL = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en_proc,
    input  logic [ADDR_W-1:0]    nproj,
    input  logic [ADDR_W-1:0]    nstub,
    output logic [ADDR_W-1:0]    read_proj,
    input  logic [WORD_W-1:0]    vm_projection,
    output logic [ADDR_W-1:0]    read_stub,
    input  logic [WORD_W-1:0]    vm_stub,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_add,
    output logic [2*IDX_W-1:0]   match,
    output logic [ADDR_W-1:0]    nmatch,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);

    state_t              state;
    logic [ADDR_W-1:0]   nproj_q;
    logic [ADDR_W-1:0]   nstub_q;
    logic [WORD_W-1:0]   proj_q;
    logic                stub_vld;
    logic                full_c;
    logic                cmp_en_c;
    logic                hit_c;

    // Candidate memory is full once its last address is reached; stay there
    assign full_c   = (nmatch == {ADDR_W{1'b1}});
    assign cmp_en_c = stub_vld && !full_c;

    vm_match_compare #(
        .IDX_W   (IDX_W),
        .PHI_TOL (PHI_TOL)
    ) u_cmp (
        .clk       (clk),
        .reset     (reset),
        .en        (cmp_en_c),
        .proj_word (proj_q),
        .stub_word (vm_stub),
        .hit_c     (hit_c),
        .hit       (wr_en),
        .pair      (match)
    );

    // Scan sequencer plus match bookkeeping; read_proj/read_stub double as p/k
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            read_proj <= '0;
            read_stub <= '0;
            wr_add    <= '0;
            nmatch    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            nproj_q   <= '0;
            nstub_q   <= '0;
            proj_q    <= '0;
            stub_vld  <= 1'b0;
        end else begin
            done     <= 1'b0;
            stub_vld <= 1'b0;

            // Stub data read last cycle is compared now; write lands this edge
            if (stub_vld && hit_c) begin
                if (full_c) begin
                    overflow <= 1'b1;
                end else begin
                    wr_add <= nmatch;
                    nmatch <= nmatch + ADDR_W'(1);
                end
            end

            case (state)
                ST_IDLE: begin
                    if (en_proc) begin
                        nproj_q   <= nproj;
                        nstub_q   <= nstub;
                        read_proj <= '0;
                        read_stub <= '0;
                        nmatch    <= '0;
                        overflow  <= 1'b0;
                        wr_add    <= '0;
                        busy      <= 1'b1;
                        // An empty event has nothing to load: finish directly
                        state     <= (nproj == '0 || nstub == '0) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    read_stub <= '0;
                    state     <= ST_SCAN;
                end
                ST_SCAN: begin
                    stub_vld <= 1'b1;
                    if (read_stub == '0) begin
                        proj_q <= vm_projection;
                    end
                    if (read_stub + ADDR_W'(1) == nstub_q) begin
                        state <= ST_NEXT;
                    end else begin
                        read_stub <= read_stub + ADDR_W'(1);
                    end
                end
                ST_NEXT: begin
                    if (read_proj + ADDR_W'(1) == nproj_q) begin
                        state <= ST_DONE;
                    end else begin
                        read_proj <= read_proj + ADDR_W'(1);
                        state     <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
